// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and helpers: block type, padding constant,
// block-count and padding-word functions.
package sha256_pkg;

  typedef logic [15:0][31:0] sha256_block_t;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

  // Number of 512-bit blocks for an n-word message after padding.
  function automatic int unsigned sha256_num_blocks(input int unsigned n);
    return (n + 32'd18) / 32'd16;
  endfunction

  // Content of a word that lies past the message body (g >= n).
  function automatic logic [31:0] sha256_pad_word(input logic [15:0] g,
                                                  input logic [15:0] n,
                                                  input logic        last,
                                                  input logic [3:0]  k);
    logic [31:0] w;
    w = '0;
    if (g == n)                 w = SHA256_PAD_WORD;
    else if (last && k == 4'd14) w = '0;
    else if (last && k == 4'd15) w = 32'(n) << 5;
    return w;
  endfunction

endpackage

// File: rtl/sha256_block_feeder_if.sv
// Block handoff bus between the feeder and the compression core.
interface sha256_block_feeder_if;
  import sha256_pkg::*;

  logic          blk_valid;
  logic          blk_ready;
  logic          blk_last;
  sha256_block_t blk_data;

  modport master (output blk_valid, blk_data, blk_last, input blk_ready);
  modport slave  (input blk_valid, blk_data, blk_last, output blk_ready);
endinterface

// File: rtl/sha256_block_feeder.sv
// Reads a fixed-length message from word memory, applies SHA-256 padding
// and presents it one 512-bit block at a time.
module sha256_block_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [15:0]                  message_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_clk,
  output logic                         mem_we,
  output logic [15:0]                  mem_addr,
  input  logic [31:0]                  mem_read_data,
  sha256_block_feeder_if.master        blk
);

  localparam int unsigned NB     = sha256_num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] N16    = 16'(NUM_OF_WORDS);
  localparam logic [11:0] LAST_B = 12'(NB - 1);

  if (NUM_OF_WORDS == 0 || NUM_OF_WORDS > 4000) begin : g_bad_len
    $error("sha256_block_feeder: NUM_OF_WORDS must be in 1..4000");
  end

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

  state_t      state, state_d;
  logic [15:0] base;
  logic [11:0] b;
  logic [4:0]  cnt;
  logic        cap_vld;
  logic [3:0]  cap_k;
  logic        cap_mem;
  logic [31:0] cap_pad;

  logic [15:0] g, g_inc, nxt_blk_g;
  logic [11:0] b_nxt;
  logic        last_blk, xfer;

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;

  assign g         = {b, cnt[3:0]};
  assign g_inc     = g + 16'd1;
  assign b_nxt     = b + 12'd1;
  assign nxt_blk_g = {b_nxt, 4'h0};
  assign last_blk  = (b == LAST_B);
  assign xfer      = blk.blk_valid && blk.blk_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (cnt == 5'd16) state_d = PRESENT;
      PRESENT: if (xfer) state_d = last_blk ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address generation, read pipeline and block register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      base          <= '0;
      b             <= '0;
      cnt           <= '0;
      cap_vld       <= 1'b0;
      cap_k         <= '0;
      cap_mem       <= 1'b0;
      cap_pad       <= '0;
      blk.blk_valid <= 1'b0;
      blk.blk_last  <= 1'b0;
      blk.blk_data  <= '0;
    end else begin
      busy          <= (state_d == FILL) || (state_d == PRESENT);
      done          <= (state_d == DONE);
      blk.blk_valid <= (state_d == PRESENT);
      blk.blk_last  <= (state_d == PRESENT) && last_blk;
      cap_vld       <= 1'b0;

      // Word issued last cycle arrives now; padding words use the stored constant
      if (cap_vld)
        blk.blk_data[4'd15 - cap_k] <= cap_mem ? mem_read_data : cap_pad;

      case (state)
        IDLE: begin
          if (start) begin
            base     <= message_addr;
            b        <= '0;
            cnt      <= '0;
            mem_addr <= message_addr;
          end
        end
        FILL: begin
          if (cnt != 5'd16) begin
            cnt     <= cnt + 5'd1;
            cap_vld <= 1'b1;
            cap_k   <= cnt[3:0];
            cap_mem <= (g < N16);
            cap_pad <= sha256_pad_word(g, N16, last_blk, cnt[3:0]);
            if (cnt != 5'd15 && g_inc < N16) mem_addr <= base + g_inc;
          end
        end
        PRESENT: begin
          if (xfer && !last_blk) begin
            b   <= b_nxt;
            cnt <= '0;
            if (nxt_blk_g < N16) mem_addr <= base + nxt_blk_g;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
